// File: rtl/pes_ram_pkg.sv
// pes_ram_pkg: shared FSM encoding and elaboration helpers
// for the parametrised dual-port scratch RAM.
package pes_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 1) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pes_ram_rd_pipe.sv
// pes_ram_rd_pipe: per-port read valid/data delay line,
// one or two stages; data holds between valid pulses.
module pes_ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);

    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= vld_in;
            if (vld_in) d1 <= data_in;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              v2;
        logic [DATA_W-1:0] d2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end

        assign vld_out  = v2;
        assign data_out = d2;
    end else begin : g_lat1
        assign vld_out  = v1;
        assign data_out = d1;
    end

endmodule

// File: rtl/pes_dpram_ctrl.sv
// pes_dpram_ctrl: true dual-port RAM with byte enables,
// read latency 1/2, write-collision merge and zero-fill sweep.
module pes_dpram_ctrl
    import pes_ram_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 64,
    parameter  int RD_LAT  = 1,
    parameter  bit PRIO_A  = 1'b1,
    parameter  bit INIT_EN = 1'b1,
    localparam int NB      = DATA_W / 8,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [NB-1:0]     be_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [NB-1:0]     be_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              coll,
    output logic [15:0]       io_oeb
);

    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_w
        $error("pes_dpram_ctrl: DATA_W must be a multiple of 8");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_d
        $error("pes_dpram_ctrl: DEPTH must be a power of two");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_l
        $error("pes_dpram_ctrl: RD_LAT must be 1 or 2");
    end

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam ram_state_t        RST_ST = INIT_EN ? ST_INIT : ST_RUN;

    ram_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              act;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic              lo_wr, hi_wr;
    logic [NB-1:0]     lo_be, hi_be;
    logic [ADDR_W-1:0] lo_addr, hi_addr;
    logic [DATA_W-1:0] lo_data, hi_data;

    assign busy   = (state == ST_INIT);
    assign io_oeb = 16'h0000;

    // rst_n gates writes so INIT_EN=0 cannot store while held in reset
    assign act  = (state == ST_RUN) && rst_n;
    assign wr_a = act && req_a && we_a;
    assign wr_b = act && req_b && we_b;
    assign rd_a = act && req_a && !we_a;
    assign rd_b = act && req_b && !we_b;

    assign lo_wr   = PRIO_A ? wr_b    : wr_a;
    assign lo_be   = PRIO_A ? be_b    : be_a;
    assign lo_addr = PRIO_A ? addr_b  : addr_a;
    assign lo_data = PRIO_A ? wdata_b : wdata_a;
    assign hi_wr   = PRIO_A ? wr_a    : wr_b;
    assign hi_be   = PRIO_A ? be_a    : be_b;
    assign hi_addr = PRIO_A ? addr_a  : addr_b;
    assign hi_data = PRIO_A ? wdata_a : wdata_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_ST;
            cnt   <= '0;
            coll  <= 1'b0;
        end else begin
            coll <= wr_a && wr_b && (addr_a == addr_b);
            unique case (state)
                ST_INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (clr && INIT_EN) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: state <= RST_ST;
            endcase
        end
    end

    // winner lanes land last, so they override the loser per byte
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lo_wr && lo_be[i])
                    mem[lo_addr][8*i +: 8] <= lo_data[8*i +: 8];
                if (hi_wr && hi_be[i])
                    mem[hi_addr][8*i +: 8] <= hi_data[8*i +: 8];
            end
        end
    end

    pes_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_in   (rd_a),
        .data_in  (mem[addr_a]),
        .vld_out  (rvalid_a),
        .data_out (rdata_a)
    );

    pes_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_in   (rd_b),
        .data_in  (mem[addr_b]),
        .vld_out  (rvalid_b),
        .data_out (rdata_b)
    );

endmodule
